bound_line_sched: RTL

BOUND_LINE_SCHED -- requirements
Module: bound_line_sched

---
 rtl/bound_line_sched.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/bound_line_sched.sv
// bound_line_sched: write/read scheduler for a KSZ-line border-replicating line buffer.
// The write side stores up to IH lines of IW pixels into NL circular line slots.
// The read side replays OH padded lines, one per H_TOTAL clocks, replicating the
// first and last source lines PAD times. Optional feature macro:
// BOUND_SCHED_OVR_CNT_EN adds ovr_cnt[7:0], a saturating dropped-frame counter.
module bound_line_sched #(
    parameter int KSZ     = 5,
    parameter int IW      = 4,
    parameter int IH      = 2,
    parameter int H_TOTAL = 6,
    localparam int PAD    = (KSZ - 1) / 2,
    localparam int NL     = PAD + 2,
    localparam int AW     = $clog2(NL * IW),
    localparam int OH     = IH + 2 * PAD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_vsync,
    input  logic          din_hsync,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          dout_vsync,
    output logic          dout_hsync,
    output logic          ovr_err
`ifdef BOUND_SCHED_OVR_CNT_EN
    ,
    output logic [7:0]    ovr_cnt
`endif
);

    localparam int CW = $clog2(IW + 1);
    localparam int LW = $clog2(IH + 1);
    localparam int PW = $clog2(H_TOTAL + 1);
    localparam int SW = $clog2(OH + 2);
    localparam logic [CW-1:0] IW_C     = CW'(IW);
    localparam logic [LW-1:0] IH_C     = LW'(IH);
    localparam logic [PW-1:0] PH_LAST  = PW'(H_TOTAL - 1);
    localparam logic [PW-1:0] PH_IW    = PW'(IW);
    localparam logic [PW-1:0] PH_IW_M1 = PW'(IW - 1);
    localparam logic [SW-1:0] SLOT_OH  = SW'(OH);

    typedef enum logic [1:0] {IDLE, ACQ, RUN} state_t;

    state_t          state_reg, state_next;
    logic            vsync_d_reg, hsync_d_reg;
    logic            wr_act_reg, wr_act_next;
    logic [LW-1:0]   line_reg, line_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [PW-1:0]   ph_reg, ph_next;
    logic [SW-1:0]   slot_reg, slot_next;
    logic            wr_en_reg, wr_en_next;
    logic [AW-1:0]   wr_addr_reg, wr_addr_next;
    logic            rd_en_reg, rd_en_next;
    logic [AW-1:0]   rd_addr_reg, rd_addr_next;
    logic            dv_reg, dv_next;
    logic            dh_reg, dh_next;
    logic            ovr_reg, ovr_next;
`ifdef BOUND_SCHED_OVR_CNT_EN
    logic [7:0]      cnt_reg, cnt_next;
`endif

    logic vs_rise, vs_fall, hs_fall, last_rd;

    // Ring-buffer address of a pixel: line slot times width plus column.
    function automatic logic [AW-1:0] line_addr(input int line, input int col);
        return AW'(((line % NL) * IW) + col);
    endfunction

    // Source line for padded output line j, replicating the image borders.
    function automatic int src_line(input int j);
        int s;
        s = j - PAD;
        if (s < 0)
            s = 0;
        else if (s > IH - 1)
            s = IH - 1;
        return s;
    endfunction

    assign vs_rise = din_vsync & ~vsync_d_reg;
    assign vs_fall = ~din_vsync & vsync_d_reg;
    assign hs_fall = hsync_d_reg & ~din_hsync;
    assign last_rd = (slot_reg == SLOT_OH) && (ph_reg == PH_IW_M1);

    // Next-state, counter and registered-output logic for both sides.
    always_comb begin
        state_next   = state_reg;
        wr_act_next  = wr_act_reg;
        line_next    = line_reg;
        col_next     = col_reg;
        ph_next      = ph_reg;
        slot_next    = slot_reg;
        ovr_next     = ovr_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr_reg;
        dv_next      = (state_reg == RUN) && (slot_reg != '0);
        dh_next      = rd_en_reg;
`ifdef BOUND_SCHED_OVR_CNT_EN
        cnt_next     = cnt_reg;
`endif

        // Write side: only the frame that started this run, clipped to IW x IH.
        if (state_reg != IDLE) begin
            wr_en_next = wr_act_reg && din_vsync && din_hsync &&
                         (col_reg < IW_C) && (line_reg < IH_C);
            if (wr_en_next)
                wr_addr_next = line_addr(int'(line_reg), int'(col_reg));
            if (!din_hsync)
                col_next = '0;
            else if (col_reg < IW_C)
                col_next = col_reg + CW'(1);
            if (hs_fall && (line_reg < IH_C))
                line_next = line_reg + LW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (vs_rise) begin
                    state_next  = ACQ;
                    wr_act_next = 1'b1;
                    line_next   = '0;
                    col_next    = '0;
                end
            end
            ACQ: begin
                if (din_hsync) begin
                    state_next = RUN;
                    ph_next    = '0;
                    slot_next  = '0;
                end
            end
            RUN: begin
                if (last_rd) begin
                    state_next = IDLE;
                end else if (ph_reg == PH_LAST) begin
                    ph_next   = '0;
                    slot_next = slot_reg + SW'(1);
                end else begin
                    ph_next = ph_reg + PW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // A new frame arriving while busy is dropped and flagged.
        if (vs_rise && (state_reg != IDLE)) begin
            ovr_next    = 1'b1;
            wr_act_next = 1'b0;
`ifdef BOUND_SCHED_OVR_CNT_EN
            if (cnt_reg != 8'hFF)
                cnt_next = cnt_reg + 8'd1;
`endif
        end
        if (vs_fall)
            wr_act_next = 1'b0;

        // Read side: line period 0 is acquisition, periods 1..OH are output slots.
        if ((state_next == RUN) && (slot_next != '0) && (slot_next <= SLOT_OH) &&
            (ph_next < PH_IW)) begin
            rd_en_next   = 1'b1;
            rd_addr_next = line_addr(src_line(int'(slot_next) - 1), int'(ph_next));
        end
    end

    // State and output registers; vsync history resets high so a frame already
    // in progress at reset release is not mistaken for a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            vsync_d_reg <= 1'b1;
            hsync_d_reg <= 1'b0;
            wr_act_reg  <= 1'b0;
            line_reg    <= '0;
            col_reg     <= '0;
            ph_reg      <= '0;
            slot_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            dv_reg      <= 1'b0;
            dh_reg      <= 1'b0;
            ovr_reg     <= 1'b0;
`ifdef BOUND_SCHED_OVR_CNT_EN
            cnt_reg     <= 8'd0;
`endif
        end else begin
            state_reg   <= state_next;
            vsync_d_reg <= din_vsync;
            hsync_d_reg <= din_hsync;
            wr_act_reg  <= wr_act_next;
            line_reg    <= line_next;
            col_reg     <= col_next;
            ph_reg      <= ph_next;
            slot_reg    <= slot_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            rd_en_reg   <= rd_en_next;
            rd_addr_reg <= rd_addr_next;
            dv_reg      <= dv_next;
            dh_reg      <= dh_next;
            ovr_reg     <= ovr_next;
`ifdef BOUND_SCHED_OVR_CNT_EN
            cnt_reg     <= cnt_next;
`endif
        end
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign rd_en      = rd_en_reg;
    assign rd_addr    = rd_addr_reg;
    assign dout_vsync = dv_reg;
    assign dout_hsync = dh_reg;
    assign ovr_err    = ovr_reg;
`ifdef BOUND_SCHED_OVR_CNT_EN
    assign ovr_cnt    = cnt_reg;
`endif

endmodule
